// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock / reset sequencer.
// The state enum values double as the state_o debug encodings.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL locked flag into the refclk domain.
// q lags d by two refclk cycles.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock qualification and ordered domain reset release.
// Optional WAIT_LOCK retry timeout: define PLL_SEQ_TIMEOUT_EN.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 3,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP    = 64,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int CNT_W          = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic [CNT_W-1:0]     lock_loss_cnt,
    output logic [CNT_W-1:0]     retry_cnt,
    output logic [2:0]           state_o
);

    localparam int TMR_MAX = max3(PLL_RST_CYCLES, STABLE_CYCLES, RELEASE_GAP);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts as stable cycle one.
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 2);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(RELEASE_GAP - 1);

    if (N_DOMAINS < 1 || PLL_RST_CYCLES < 1 || STABLE_CYCLES < 2 ||
        RELEASE_GAP < 1 || LOCK_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("pll_lock_reset_seq: invalid parameter set");
    end

    pll_state_e       state;
    logic [TMR_W-1:0] tmr;
    logic             locked_s;

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int WL_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [WL_W-1:0] WL_LAST = WL_W'(LOCK_TIMEOUT - 1);

    logic [WL_W-1:0]  wl_tmr;
    logic [CNT_W-1:0] retry_q;

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = '0;
`endif

    assign state_o = state;

    pll_lock_sync u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= PLL_RST;
            tmr           <= '0;
            pll_rst       <= 1'b1;
            rst_out       <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
            wl_tmr        <= '0;
            retry_q       <= '0;
`endif
        end else begin
            unique case (state)
                PLL_RST: begin
                    pll_rst <= 1'b1;
                    if (tmr == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        pll_rst <= 1'b0;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    pll_rst <= 1'b0;
                    if (locked_s) begin
                        state <= STABLE;
                        tmr   <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
                        wl_tmr <= '0;
                    end else if (wl_tmr == WL_LAST) begin
                        state   <= PLL_RST;
                        pll_rst <= 1'b1;
                        tmr     <= '0;
                        wl_tmr  <= '0;
                        if (retry_q != '1)
                            retry_q <= retry_q + CNT_W'(1);
                    end else begin
                        wl_tmr <= wl_tmr + WL_W'(1);
`endif
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        // Glitch only: no counter change.
                        state <= WAIT_LOCK;
                        tmr   <= '0;
                    end else if (tmr == STB_LAST) begin
                        state   <= RELEASE;
                        rst_out <= rst_out << 1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                RELEASE: begin
                    if (!locked_s) begin
                        state   <= PLL_RST;
                        pll_rst <= 1'b1;
                        rst_out <= '1;
                        ready   <= 1'b0;
                        tmr     <= '0;
                        if (lock_loss_cnt != '1)
                            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
                    end else if (!rst_out[N_DOMAINS-1]) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else if (tmr == GAP_LAST) begin
                        rst_out <= rst_out << 1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state   <= PLL_RST;
                        pll_rst <= 1'b1;
                        rst_out <= '1;
                        ready   <= 1'b0;
                        tmr     <= '0;
                        if (lock_loss_cnt != '1)
                            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= PLL_RST;
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                    tmr     <= '0;
                end
            endcase
        end
    end

endmodule
